// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, funct3 encodings, FSM state encoding and op-class helper.
package md_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 datapath: one shift-add (multiply) or restoring step (divide) per step cycle.
// Operates on magnitudes only; sign handling and result selection live in the parent.
module md_iter_core #(
  parameter int XLEN = md_pkg::XLEN
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_op,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic              last_step,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);
  import md_pkg::*;

  localparam int CW = $clog2(XLEN);

  // Shared accumulator: multiply keeps {hi, lo} product, divide keeps {rem, quot}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_q};

    if (load) begin
      acc_d = {{XLEN{1'b0}}, mag_a};
      b_d   = mag_b;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_op) begin
        // Remainder stays below |b|, so a non-borrowing difference fits XLEN bits.
        if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_step = step && (cnt_q == CW'(XLEN-1));
  assign prod      = acc_q;
  assign quot      = acc_q[XLEN-1:0];
  assign rem       = acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M mul/div: start on rising edge of clk_ctl_mul_div, XLEN+1 cycles
// with alu_complete low (1 cycle for divide special cases); edges while busy are ignored.
module mul_div_unit #(
  parameter int XLEN = md_pkg::XLEN
) (
  input  logic            clk_100M,
  input  logic            rst,
  input  logic            clk_ctl_mul_div,
  input  logic            md_en,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] md_result,
  output logic            md_busy,
  output logic            alu_complete
);
  import md_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic            strobe_q, strobe_d;
  logic [2:0]      f3_q, f3_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            spec_q, spec_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [XLEN-1:0] md_result_q, md_result_d;
  logic            alu_complete_q, alu_complete_d;
  logic            md_busy_q, md_busy_d;

  logic            start, accept;
  logic            a_signed, b_signed, neg_a, neg_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_val, fix_res;
  logic            op_div, last_step;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quot_raw, rem_raw;

  assign start  = clk_ctl_mul_div & ~strobe_q;
  assign accept = (state_q == ST_IDLE) && start && md_en;
  assign op_div = is_div(f3_q);

  always_comb begin
    a_signed = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    neg_a    = a_signed && rs1_data[XLEN-1];
    neg_b    = b_signed && rs2_data[XLEN-1];
    mag_a    = neg_a ? -rs1_data : rs1_data;
    mag_b    = neg_b ? -rs2_data : rs2_data;
    div_zero = (rs2_data == '0);
    div_ovf  = (funct3 inside {F3_DIV, F3_REM}) && (rs1_data == MIN_NEG) && (rs2_data == '1);
    special  = is_div(funct3) && (div_zero || div_ovf);
    if (div_zero) spec_val = funct3[1] ? rs1_data : '1;
    else          spec_val = funct3[1] ? '0 : rs1_data;
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .load      (accept),
    .step      (state_q == ST_CALC),
    .div_op    (op_div),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .last_step (last_step),
    .prod      (prod_raw),
    .quot      (quot_raw),
    .rem       (rem_raw)
  );

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
    if (spec_q)           fix_res = spec_res_q;
    else if (op_div) begin
      if (f3_q[1])        fix_res = sign_a_q ? -rem_raw : rem_raw;
      else                fix_res = (sign_a_q ^ sign_b_q) ? -quot_raw : quot_raw;
    end
    else if (f3_q == F3_MUL) fix_res = prod_fix[XLEN-1:0];
    else                  fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d        = state_q;
    strobe_d       = clk_ctl_mul_div;
    f3_d           = f3_q;
    sign_a_d       = sign_a_q;
    sign_b_d       = sign_b_q;
    spec_d         = spec_q;
    spec_res_d     = spec_res_q;
    md_result_d    = md_result_q;
    alu_complete_d = alu_complete_q;
    md_busy_d      = md_busy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_d           = funct3;
          sign_a_d       = neg_a;
          sign_b_d       = neg_b;
          spec_d         = special;
          spec_res_d     = spec_val;
          alu_complete_d = 1'b0;
          md_busy_d      = 1'b1;
          state_d        = special ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_step) state_d = ST_FIX;
      end
      ST_FIX: begin
        md_result_d    = fix_res;
        alu_complete_d = 1'b1;
        md_busy_d      = 1'b0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      strobe_q       <= 1'b0;
      f3_q           <= '0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      spec_q         <= 1'b0;
      spec_res_q     <= '0;
      md_result_q    <= '0;
      alu_complete_q <= 1'b1;
      md_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      strobe_q       <= strobe_d;
      f3_q           <= f3_d;
      sign_a_q       <= sign_a_d;
      sign_b_q       <= sign_b_d;
      spec_q         <= spec_d;
      spec_res_q     <= spec_res_d;
      md_result_q    <= md_result_d;
      alu_complete_q <= alu_complete_d;
      md_busy_q      <= md_busy_d;
    end
  end

  assign md_result    = md_result_q;
  assign alu_complete = alu_complete_q;
  assign md_busy      = md_busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: RV32M reference model with a countdown latency model,
// per-cycle output compare plus directed literal checks and randomized ops.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic        md_en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] md_result;
  logic        md_busy;
  logic        alu_complete;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .clk_100M        (clk),
    .rst             (rst),
    .clk_ctl_mul_div (strobe),
    .md_en           (md_en),
    .funct3          (funct3),
    .rs1_data        (rs1),
    .rs2_data        (rs2),
    .md_result       (md_result),
    .md_busy         (md_busy),
    .alu_complete    (alu_complete)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RV32M semantics via 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Behavioural timing model: cycles remaining until the result is published.
  logic        m_prev = 1'b0, m_ac = 1'b1, m_busy = 1'b0;
  logic [31:0] m_res = '0, m_pend = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_prev = 1'b0; m_left = 0; m_res = '0; m_ac = 1'b1; m_busy = 1'b0;
    end else begin
      logic m_start;
      m_start = strobe && !m_prev;
      m_prev  = strobe;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_res = m_pend; m_ac = 1'b1; m_busy = 1'b0; end
      end else if (m_start && md_en) begin
        m_pend = ref_md(funct3, rs1, rs2);
        m_left = is_special(funct3, rs1, rs2) ? 1 : 33;
        m_ac   = 1'b0;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_alu_complete", {31'b0, alu_complete}, {31'b0, m_ac});
      chk("cyc_md_busy",      {31'b0, md_busy},      {31'b0, m_busy});
      chk("cyc_md_result",    md_result,             m_res);
    end
  end

  // Launch one op, hold the strobe `hold` cycles, optionally re-pulse it at loop index `retrig`.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int retrig, input logic [31:0] exp_v,
                        input int exp_low, input string nm);
    int low;
    low = 0;
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; md_en = 1'b1; strobe = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (t + 1 >= hold) strobe = 1'b0;
      if (retrig >= 0 && t == retrig) strobe = 1'b1;
      if (retrig >= 0 && t == retrig + 1) strobe = 1'b0;
      if (!alu_complete) low++;
      else if (low > 0) break;
    end
    strobe = 1'b0;
    chk({nm, "_low_cycles"}, low, exp_low);
    chk({nm, "_result"}, md_result, exp_v);
  endtask

  task automatic expect_quiet(input int n, input string nm);
    int low;
    low = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!alu_complete) low++;
    end
    chk({nm, "_quiet"}, low, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_alu_complete", {31'b0, alu_complete}, 32'd1);
    chk("rst_md_busy",      {31'b0, md_busy},      32'd0);
    chk("rst_md_result",    md_result,             32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 3, -1, 32'hFFFF_FFEB, 33, "mul_7_m3");
    expect_quiet(5, "mul_hold_no_retrigger");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, -1, 32'h4000_0000, 33, "mulh_min");
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 2, -1, 32'hC000_0000, 33, "mulhsu_min");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 1, -1, 32'h4000_0000, 33, "mulhu_min");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1, -1, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1, -1, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 1, -1, 32'd14, 33, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 1, -1, 32'd2, 33, "remu_100_7");
    run_op(3'd5, 32'h1234, 32'd0, 1, -1, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(3'd7, 32'h1234, 32'd0, 1, -1, 32'h0000_1234, 1, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 32'h0000_0000, 1, "rem_ovf");

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 10, 32'hFFFF_FFFE, 33, "retrig_calc10");
    expect_quiet(3, "retrig_after");

    @(negedge clk);
    md_en = 1'b0; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    expect_quiet(6, "md_en_low");
    chk("md_en_low_result", md_result, 32'hFFFF_FFFE);

    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; md_en = 1'b1; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_rst_alu_complete", {31'b0, alu_complete}, 32'd1);
    chk("midop_rst_md_busy",      {31'b0, md_busy},      32'd0);
    chk("midop_rst_md_result",    md_result,             32'd0);
    rst = 1'b0;
    run_op(3'd0, 32'd12, 32'd11, 1, -1, 32'd132, 33, "after_rst_mul");

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = 32'($urandom_range(0, 20));
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        3: b = 32'($urandom_range(0, 20));
        default: b = $urandom();
      endcase
      run_op(f3, a, b, $urandom_range(1, 5), -1, ref_md(f3, a, b),
             is_special(f3, a, b) ? 1 : 33, "rand");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
